// File: rtl/aes_pkg.sv
// Shared AES core definitions: key length codes, controller state encodings
// and error cause codes used by the core controller and its sub-blocks.
package aes_pkg;

  localparam logic [3:0] AES_128_BIT_KEY = 4'd0;
  localparam logic [3:0] AES_192_BIT_KEY = 4'd1;
  localparam logic [3:0] AES_256_BIT_KEY = 4'd2;

  typedef enum logic [2:0] {
    CTRL_IDLE      = 3'd0,
    CTRL_KEY_START = 3'd1,
    CTRL_KEY_WAIT  = 3'd2,
    CTRL_ENC_START = 3'd3,
    CTRL_ENC_WAIT  = 3'd4
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BAD_KEYLEN = 2'd1,
    ERR_NO_KEY     = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } err_code_e;

  function automatic logic keylen_is_valid(input logic [3:0] code);
    return (code == AES_128_BIT_KEY) ||
           (code == AES_192_BIT_KEY) ||
           (code == AES_256_BIT_KEY);
  endfunction

endpackage

// File: rtl/aes_watchdog.sv
// Clear/enable busy counter with a terminal-count flag; the controller uses
// it both to abort hung sub-blocks and to recognise the first WAIT cycle.
module aes_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  // Saturates at the limit so a controller that lingers cannot wrap it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/aes_core_ctrl.sv
// AES core control FSM: accepts init/next commands, pulses the key expansion
// and encipher start strobes, owns the shared s-box mux and the status flags.
module aes_core_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        next,
  input  logic [3:0]  keylen,
  output logic [3:0]  keylen_q,
  output logic        key_init,
  input  logic        key_ready,
  output logic        enc_next,
  input  logic        enc_ready,
  input  logic [31:0] key_sboxw,
  input  logic [31:0] enc_sboxw,
  output logic [31:0] sboxw,
  output logic        ready,
  output logic        key_valid,
  output logic        result_valid,
  output logic        error,
  output logic [1:0]  err_code
);

  ctrl_state_e state;
  ctrl_state_e state_next;

  logic [3:0]       keylen_next;
  logic             key_valid_next;
  logic             result_valid_next;
  logic             error_next;
  logic [1:0]       err_code_next;

  logic             wd_clear;
  logic             wd_enable;
  logic [CNT_W-1:0] wd_count;
  logic             wd_expired;
  logic             guard;

  aes_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .count  (wd_count),
    .expired(wd_expired)
  );

  // The counter is cleared in START, so zero marks the guard cycle in WAIT.
  assign wd_enable = (state == CTRL_KEY_WAIT) || (state == CTRL_ENC_WAIT);
  assign guard     = (wd_count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= CTRL_IDLE;
      keylen_q     <= AES_128_BIT_KEY;
      key_valid    <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      state        <= state_next;
      keylen_q     <= keylen_next;
      key_valid    <= key_valid_next;
      result_valid <= result_valid_next;
      error        <= error_next;
      err_code     <= err_code_next;
    end
  end

  always_comb begin
    state_next        = state;
    keylen_next       = keylen_q;
    key_valid_next    = key_valid;
    result_valid_next = result_valid;
    error_next        = 1'b0;
    err_code_next     = err_code;
    wd_clear          = 1'b0;
    key_init          = 1'b0;
    enc_next          = 1'b0;

    case (state)
      CTRL_IDLE: begin
        // init takes priority; a simultaneous next is dropped.
        if (init) begin
          if (keylen_is_valid(keylen)) begin
            keylen_next       = keylen;
            key_valid_next    = 1'b0;
            result_valid_next = 1'b0;
            err_code_next     = ERR_NONE;
            state_next        = CTRL_KEY_START;
          end else begin
            error_next    = 1'b1;
            err_code_next = ERR_BAD_KEYLEN;
          end
        end else if (next) begin
          if (key_valid) begin
            result_valid_next = 1'b0;
            err_code_next     = ERR_NONE;
            state_next        = CTRL_ENC_START;
          end else begin
            error_next    = 1'b1;
            err_code_next = ERR_NO_KEY;
          end
        end
      end

      CTRL_KEY_START: begin
        key_init   = 1'b1;
        wd_clear   = 1'b1;
        state_next = CTRL_KEY_WAIT;
      end

      CTRL_KEY_WAIT: begin
        if (!guard && key_ready) begin
          key_valid_next = 1'b1;
          state_next     = CTRL_IDLE;
        end else if (wd_expired) begin
          error_next        = 1'b1;
          err_code_next     = ERR_TIMEOUT;
          key_valid_next    = 1'b0;
          result_valid_next = 1'b0;
          state_next        = CTRL_IDLE;
        end
      end

      CTRL_ENC_START: begin
        enc_next   = 1'b1;
        wd_clear   = 1'b1;
        state_next = CTRL_ENC_WAIT;
      end

      CTRL_ENC_WAIT: begin
        if (!guard && enc_ready) begin
          result_valid_next = 1'b1;
          state_next        = CTRL_IDLE;
        end else if (wd_expired) begin
          error_next        = 1'b1;
          err_code_next     = ERR_TIMEOUT;
          key_valid_next    = 1'b0;
          result_valid_next = 1'b0;
          state_next        = CTRL_IDLE;
        end
      end

      default: begin
        state_next = CTRL_IDLE;
      end
    endcase
  end

  assign ready = (state == CTRL_IDLE);
  assign sboxw = ((state == CTRL_ENC_START) || (state == CTRL_ENC_WAIT)) ? enc_sboxw : key_sboxw;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Directed self-checking bench for aes_core_ctrl with stub sub-block handshakes
// and a shortened watchdog limit.
module tb_aes_core_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init;
  logic        next;
  logic [3:0]  keylen;
  logic [3:0]  keylen_q;
  logic        key_init;
  logic        key_ready;
  logic        enc_next;
  logic        enc_ready;
  logic [31:0] key_sboxw;
  logic [31:0] enc_sboxw;
  logic [31:0] sboxw;
  logic        ready;
  logic        key_valid;
  logic        result_valid;
  logic        error;
  logic [1:0]  err_code;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] KEY_WORD = 32'hA5A5_0001;
  localparam logic [31:0] ENC_WORD = 32'h5A5A_0002;

  aes_core_ctrl #(
    .TIMEOUT_CYCLES(20),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .init        (init),
    .next        (next),
    .keylen      (keylen),
    .keylen_q    (keylen_q),
    .key_init    (key_init),
    .key_ready   (key_ready),
    .enc_next    (enc_next),
    .enc_ready   (enc_ready),
    .key_sboxw   (key_sboxw),
    .enc_sboxw   (enc_sboxw),
    .sboxw       (sboxw),
    .ready       (ready),
    .key_valid   (key_valid),
    .result_valid(result_valid),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Idle-state outputs expected after reset.
  task automatic check_reset_values(input string tag);
    check({tag, ".ready"}, ready, 1);
    check({tag, ".key_init"}, key_init, 0);
    check({tag, ".enc_next"}, enc_next, 0);
    check({tag, ".key_valid"}, key_valid, 0);
    check({tag, ".result_valid"}, result_valid, 0);
    check({tag, ".error"}, error, 0);
    check({tag, ".err_code"}, err_code, 0);
    check({tag, ".keylen_q"}, keylen_q, 0);
  endtask

  // Full key expansion with key_ready already high: done three edges after accept.
  task automatic key_flow(input logic [3:0] code, input string tag);
    keylen = code; init = 1'b1; key_ready = 1'b1;
    tick();
    init = 1'b0; keylen = 4'hF;
    check({tag, ".start_ready"}, ready, 0);
    check({tag, ".key_init"}, key_init, 1);
    check({tag, ".keylen_q"}, keylen_q, 32'(code));
    check({tag, ".key_valid_cleared"}, key_valid, 0);
    tick();
    check({tag, ".key_init_one_cycle"}, key_init, 0);
    tick();
    check({tag, ".guard_ignores_ready"}, ready, 0);
    tick();
    check({tag, ".done_ready"}, ready, 1);
    check({tag, ".key_valid"}, key_valid, 1);
    check({tag, ".keylen_q_held"}, keylen_q, 32'(code));
  endtask

  // Encipherment with enc_ready already high.
  task automatic enc_flow(input string tag);
    next = 1'b1; enc_ready = 1'b1;
    tick();
    next = 1'b0;
    check({tag, ".enc_next"}, enc_next, 1);
    check({tag, ".sboxw_enc"}, sboxw, ENC_WORD);
    check({tag, ".result_cleared"}, result_valid, 0);
    tick();
    check({tag, ".enc_next_one_cycle"}, enc_next, 0);
    tick();
    check({tag, ".guard_no_result"}, result_valid, 0);
    tick();
    check({tag, ".result_valid"}, result_valid, 1);
    check({tag, ".sboxw_key"}, sboxw, KEY_WORD);
  endtask

  initial begin
    reset_n = 1'b0; init = 1'b0; next = 1'b0; keylen = 4'd0;
    key_ready = 1'b0; enc_ready = 1'b0;
    key_sboxw = KEY_WORD; enc_sboxw = ENC_WORD;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check_reset_values("reset");
    check("reset.sboxw", sboxw, KEY_WORD);

    // next without a key
    next = 1'b1;
    tick();
    next = 1'b0;
    check("nokey.error", error, 1);
    check("nokey.err_code", err_code, 2);
    check("nokey.ready", ready, 1);
    tick();
    check("nokey.error_pulse", error, 0);
    check("nokey.err_code_held", err_code, 2);

    key_flow(4'd0, "aes128");
    check("aes128.err_cleared", err_code, 0);
    enc_flow("aes128_enc");
    key_flow(4'd1, "aes192");
    enc_flow("aes192_enc");
    key_flow(4'd2, "aes256");
    enc_flow("aes256_enc");

    // invalid key length leaves the schedule alone
    keylen = 4'h5; init = 1'b1;
    tick();
    init = 1'b0;
    check("badlen.error", error, 1);
    check("badlen.err_code", err_code, 1);
    check("badlen.key_valid", key_valid, 1);
    check("badlen.ready", ready, 1);
    check("badlen.keylen_q", keylen_q, 2);
    tick();
    check("badlen.error_pulse", error, 0);

    // init and next together, then next held through KEY_WAIT
    keylen = 4'd0; init = 1'b1; next = 1'b1; key_ready = 1'b0; enc_ready = 1'b0;
    tick();
    init = 1'b0;
    check("both.key_init", key_init, 1);
    check("both.enc_next", enc_next, 0);
    check("both.err_cleared", err_code, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold.enc_next", enc_next, 0);
      check("hold.ready", ready, 0);
      check("hold.error", error, 0);
    end
    key_ready = 1'b1; next = 1'b0;
    tick();
    check("hold.done_ready", ready, 1);
    check("hold.key_valid", key_valid, 1);
    check("hold.enc_next_idle", enc_next, 0);
    tick();
    check("hold.still_idle", ready, 1);

    // re-asserted next starts encipherment; enc_ready stuck low times out
    next = 1'b1;
    tick();
    next = 1'b0;
    check("timeout.enc_next", enc_next, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("timeout.early_error", error, 0);
    end
    tick();
    check("timeout.error", error, 1);
    check("timeout.err_code", err_code, 3);
    check("timeout.key_valid", key_valid, 0);
    check("timeout.result_valid", result_valid, 0);
    check("timeout.ready", ready, 1);
    tick();
    check("timeout.error_pulse", error, 0);
    check("timeout.err_code_held", err_code, 3);

    // reset while ENC_WAIT is in flight
    key_flow(4'd2, "prereset");
    enc_ready = 1'b0; next = 1'b1;
    tick();
    next = 1'b0;
    tick(); tick();
    check("prereset.busy", ready, 0);
    reset_n = 1'b0;
    tick();
    check_reset_values("midreset");
    check("midreset.sboxw", sboxw, KEY_WORD);
    reset_n = 1'b1;
    tick();
    check("postreset.ready", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
